// File: rtl/nibble_alu_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_alu_pkg;

    localparam int NIBBLES_DEF = 2;
    localparam int SLICE_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_slice4.sv
// 4-bit ripple slice. It exposes the carry into bit 3 as well as the carry out,
// so the top level can derive signed overflow on the last nibble.
module addsub_slice4 (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    output logic [3:0] s4,
    output logic       c3,
    output logic       c4
);

    logic [3:0] lo;
    logic [1:0] hi;

    // Bits 2:0 plus carry-in. lo[3] is the carry into bit 3.
    assign lo = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b000, cin};
    assign c3 = lo[3];

    // Bit 3 is added on its own so that c3 stays visible.
    assign hi = {1'b0, a4[3]} + {1'b0, b4[3]} + {1'b0, c3};

    assign s4 = {hi[0], lo[2:0]};
    assign c4 = hi[1];

endmodule

// File: rtl/nibble_serial_alu.sv
// Nibble-serial add/subtract unit. It uses one 4-bit slice per cycle, a
// valid/ready handshake on each side, and one operation in flight at a time.
module nibble_serial_alu
    import nibble_alu_pkg::*;
#(
    parameter int NIBBLES = NIBBLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf,
    output logic                   zero
);

    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    state_t state, state_nx;

    logic [NIBBLES-1:0][SLICE_W-1:0] a_q, b_q, res_q, res_nx;
    logic                            sel_q, carry_q;
    logic [KW-1:0]                   k_q;
    logic                            last;
    logic [SLICE_W-1:0]              a_sl, b_sl, s4;
    logic                            c3, c4;

    // The handshake outputs are decoded from state only. Neither in_valid nor
    // out_ready reaches them combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign last      = (k_q == K_LAST);

    // For subtraction, B is inverted. The +1 enters through the carry register,
    // which is seeded with sel on accept.
    assign a_sl = a_q[k_q];
    assign b_sl = b_q[k_q] ^ {SLICE_W{sel_q}};

    addsub_slice4 u_slice (
        .a4  (a_sl),
        .b4  (b_sl),
        .cin (carry_q),
        .s4  (s4),
        .c3  (c3),
        .c4  (c4)
    );

    // Result with the current nibble replaced. On the last nibble it gives the
    // complete value for the zero flag.
    always_comb begin
        res_nx      = res_q;
        res_nx[k_q] = s4;
    end

    // State register. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CALC;
            CALC:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Datapath. The operands are captured only in IDLE, so later changes on
    // the inputs have no effect on an operation already accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            res_q   <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        sel_q   <= sel;
                        carry_q <= sel;
                        k_q     <= '0;
                    end
                end
                CALC: begin
                    res_q   <= res_nx;
                    carry_q <= c4;
                    k_q     <= last ? '0 : k_q + 1'b1;
                    if (last) begin
                        cout <= c4;
                        ovf  <= c3 ^ c4;
                        zero <= (res_nx == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu. Directed cases run on a NIBBLES=2 instance.
// Random handshake runs follow on NIBBLES=1, 2 and 4 instances, each compared
// against an arithmetic reference model.
module tb_nibble_serial_alu;

    localparam int OPS = 1000;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_err    = 0;
    bit go       = 1'b0;
    int done_cnt = 0;

    // Directed-test instance (NIBBLES=2).
    logic       in_valid, in_ready, sel, out_valid, out_ready, cout, ovf, zero;
    logic [7:0] a, b, result;

    nibble_serial_alu #(.NIBBLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model. It works on signed and unsigned integer values, not
    // on carry chains.
    function automatic exp_t model(input int w, input longint unsigned av,
                                   input longint unsigned bv, input bit sv);
        exp_t            e;
        longint unsigned m    = (64'd1 << w) - 64'd1;
        longint unsigned half = 64'd1 << (w - 1);
        longint          sa, sb, sr;
        sa = (av >= half) ? longint'(av) - longint'(m + 1) : longint'(av);
        sb = (bv >= half) ? longint'(bv) - longint'(m + 1) : longint'(bv);
        sr = sv ? sa - sb : sa + sb;
        e.res  = 32'((sv ? av - bv : av + bv) & m);
        e.cout = sv ? (av >= bv) : ((av + bv) > m);
        e.ovf  = (sr > longint'(half) - 1) || (sr < -longint'(half));
        e.zero = (e.res == 0);
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        chk({tag, "_res"},  32'(result), e.res);
        chk({tag, "_cout"}, 32'(cout),   32'(e.cout));
        chk({tag, "_ovf"},  32'(ovf),    32'(e.ovf));
        chk({tag, "_zero"}, 32'(zero),   32'(e.zero));
    endtask

    // Call this at posedge+1 with the DUT idle. It returns at accept edge + 1.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts);
        a = ta; b = tbv; sel = ts; in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); sel = ($urandom & 1) != 0;
    endtask

    // Counts edges from the accept edge (edge 1) to the first out_valid.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle", 32'(in_ready), 32'd1);
    endtask

    logic [7:0] dir_a   [4] = '{8'h3C, 8'h7F, 8'h10, 8'h00};
    logic [7:0] dir_b   [4] = '{8'h25, 8'h01, 8'h10, 8'h01};
    logic       dir_sel [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_t       dir_exp [4] = '{
        '{res: 32'h61, cout: 1'b0, ovf: 1'b0, zero: 1'b0},
        '{res: 32'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0},
        '{res: 32'h00, cout: 1'b1, ovf: 1'b0, zero: 1'b1},
        '{res: 32'hFF, cout: 1'b0, ovf: 1'b0, zero: 1'b0}
    };

    initial begin
        int   lat;
        int   seen;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = 1'b0;
        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_zero",      32'(zero),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors. The first one is accepted on the first edge after
        // reset is released.
        for (int i = 0; i < 4; i++) begin
            start_op(dir_a[i], dir_b[i], dir_sel[i]);
            wait_done(lat);
            chk($sformatf("dir%0d_latency", i), 32'(lat), 32'd3);
            check_out($sformatf("dir%0d", i), dir_exp[i]);
            release_out();
        end

        // Hold DONE with out_ready low while new requests are on the inputs.
        start_op(8'hA5, 8'h3C, 1'b1);
        wait_done(lat);
        e = model(8, 64'hA5, 64'h3C, 1'b1);
        in_valid = 1'b1; a = 8'h12; b = 8'h34; sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_out($sformatf("hold%0d", i), e);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hold_exit_ready", 32'(in_ready),  32'd1);
        chk("hold_exit_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("second_accept", 32'(in_ready), 32'd0);
        wait_done(lat);
        chk("second_latency", 32'(lat), 32'd3);
        check_out("second", model(8, 64'h12, 64'h34, 1'b0));
        release_out();

        // Assert reset in the middle of CALC (k=1), away from any clock edge.
        start_op(8'hF0, 8'h0F, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result",    32'(result),    32'd0);
        chk("arst_cout",      32'(cout),      32'd0);
        chk("arst_ovf",       32'(ovf),       32'd0);
        chk("arst_zero",      32'(zero),      32'd0);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("arst_no_result", 32'(seen), 32'd0);
        start_op(8'hC8, 8'h4E, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", 32'(lat), 32'd3);
        check_out("post_rst", model(8, 64'hC8, 64'h4E, 1'b0));
        release_out();

        go = 1'b1;
        wait (done_cnt == 3);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // Random handshake runs on three widths.
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int NB = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int WB = 4 * NB;

        logic          iv, ir, ov, ory, s, co, of, z;
        logic [WB-1:0] ra, rb, rr;
        logic [2*WB:0] q[$];
        int            acc = 0;

        nibble_serial_alu #(.NIBBLES(NB)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir),
            .a(ra), .b(rb), .sel(s), .out_valid(ov), .out_ready(ory),
            .result(rr), .cout(co), .ovf(of), .zero(z)
        );

        // Driver. Operands change every cycle, including while the DUT is busy.
        initial begin
            int cyc;
            iv = 1'b0; ory = 1'b0; ra = '0; rb = '0; s = 1'b0;
            wait (go);
            cyc = 0;
            while ((acc < OPS || q.size() != 0) && cyc < 30000) begin
                @(posedge clk); #1;
                cyc++;
                iv  = (acc < OPS) && (($urandom & 1) != 0);
                ra  = WB'($urandom);
                rb  = WB'($urandom);
                s   = ($urandom & 1) != 0;
                ory = ($urandom & 1) != 0;
            end
            iv = 1'b0;
            chk($sformatf("rnd%0d_accepted", NB), 32'(acc), 32'(OPS));
            chk($sformatf("rnd%0d_drained", NB), 32'(q.size()), 32'd0);
            done_cnt++;
        end

        // Monitor, sampled on the falling edge.
        always @(negedge clk) begin
            logic [2*WB:0] e;
            exp_t          x;
            if (go && rst_n) begin
                if (iv && ir) begin
                    q.push_back({s, rb, ra});
                    acc++;
                end
                if (ov && ory) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rnd%0d_spurious", NB), 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        x = model(WB, 64'(e[WB-1:0]), 64'(e[2*WB-1:WB]), e[2*WB]);
                        chk($sformatf("rnd%0d_res", NB),  32'(rr), x.res);
                        chk($sformatf("rnd%0d_cout", NB), 32'(co), 32'(x.cout));
                        chk($sformatf("rnd%0d_ovf", NB),  32'(of), 32'(x.ovf));
                        chk($sformatf("rnd%0d_zero", NB), 32'(z),  32'(x.zero));
                    end
                end
            end
        end
    end

endmodule

// File: doc/nibble_serial_alu.md
NIBBLE_SERIAL_ALU -- requirements
Module: nibble_serial_alu

Interface
REQ-001 SHALL have parameter NIBBLES, default 2, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port a  input  W  operand A.
REQ-007 SHALL have port b  input  W  operand B.
REQ-008 SHALL have port sel  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  W  sum or difference, modulo 2^W.
REQ-012 SHALL have port cout  output  1  final carry; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf  output  1  two's-complement overflow.
REQ-014 SHALL have port zero  output  1  result == 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-017 SHALL, on in_valid&&in_ready, register a, b and sel, clear the nibble index to 0, set the carry register to sel, and enter CALC.
REQ-018 SHALL, in CALC, process one nibble per cycle, index k from 0 to NIBBLES-1: slice inputs a[k], b[k]^{4{sel}} and the carry register; write the sum nibble into result[4k+3:4k]; store the slice carry-out.
REQ-019 SHALL record ovf = (carry into bit W-1) XOR (carry out of bit W-1) in the cycle k = NIBBLES-1.
REQ-020 SHALL move from CALC to DONE after the cycle k = NIBBLES-1; zero and cout SHALL be valid together with out_valid.
REQ-021 SHALL give a latency of NIBBLES+1 rising edges from the accept edge to the first cycle with out_valid=1.
REQ-022 SHALL hold result, cout, ovf and zero stable in DONE while out_ready=0, for any number of cycles.
REQ-023 SHALL, in DONE with out_ready=1, return to IDLE on that edge; no same-cycle accept (in_ready=0 in DONE); peak throughput is one operation per NIBBLES+2 cycles.
REQ-024 SHALL ignore in_valid and operand changes while in CALC or DONE; captured operands SHALL be immune.
REQ-025 SHALL treat out_ready outside DONE as a don't-care.
REQ-026 SHALL, for NIBBLES=1, spend exactly one cycle in CALC.

Reset
REQ-027 SHALL, on rst_n low, immediately (asynchronously) force state IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, zero=0, nibble index=0 and carry register=0.
REQ-028 SHALL abort any operation in flight at reset assertion and never emit its result.
REQ-029 SHALL allow the first accept on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place the state enum (IDLE/CALC/DONE) and the NIBBLES default constant in a shared package, nibble_alu_pkg.
REQ-031 SHALL instantiate one combinational sub-module, addsub_slice4 (inputs a4, b4, cin; outputs s4, c3 = carry into bit 3, c4 = carry out), reused every cycle.
REQ-032 SHALL contain no combinational path from in_valid/out_ready to in_ready/out_valid; handshake outputs SHALL be state-decoded only.

Verification (NIBBLES=2)
REQ-033 SHALL verify: a=0x3C, b=0x25, sel=0 -> result=0x61, cout=0, ovf=0, zero=0, out_valid on the 3rd edge after accept.
REQ-034 SHALL verify: a=0x7F, b=0x01, sel=0 -> result=0x80, ovf=1, cout=0.
REQ-035 SHALL verify: a=0x10, b=0x10, sel=1 -> result=0x00, zero=1, cout=1, ovf=0; a=0x00, b=0x01, sel=1 -> result=0xFF, cout=0.
REQ-036 SHALL verify: out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs unchanged, in_ready=0, no second accept until 1 cycle after out_ready=1.
REQ-037 SHALL verify: rst_n pulsed low in the CALC cycle with k=1 -> outputs go to reset values without a clock edge; no out_valid follows; the next request completes correctly.
REQ-038 SHALL verify: a random self-checking run of 1000 operations with random in_valid/out_ready against a W-bit reference model, with NIBBLES=1 and NIBBLES=4 builds included.
